pmem_bridge: RTL

//  Sits directly downstream of the multicycle cpu_control/datapath memory port.

---
 rtl/pmem_bridge_pkg.sv | 10 +
 rtl/pmem_timeout_ctr.sv | 24 ++
 rtl/pmem_bridge.sv | 78 +++++++
 3 files changed

// File: rtl/pmem_bridge_pkg.sv
// pmem_bridge_pkg: shared word/mask types and bridge FSM state encoding
package pmem_bridge_pkg;
  typedef logic [31:0] rv32i_word;
  typedef logic [3:0]  rv32i_mem_wmask;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } pmem_bridge_state_t;
endpackage

// File: rtl/pmem_timeout_ctr.sv
// pmem_timeout_ctr: saturating busy-cycle timer with expiry flag
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clear      : synchronous return to zero (wins over enable)
//   enable     : count one cycle
//   expired    : count has reached TIMEOUT_CYCLES-1; never set when TIMEOUT_CYCLES==0
module pmem_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int unsigned W = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [W-1:0] count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else if (clear) count <= '0;
    else if (enable && count != '1) count <= count + 1'b1;
  end
  assign expired = (TIMEOUT_CYCLES != 0) && (count == W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/pmem_bridge.sv
// pmem_bridge: CPU level-held memory port to req/ack physical bus bridge with timeout
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   mem_read, mem_write        : CPU requests, held until mem_resp
//   mem_address, mem_wdata     : CPU byte address and write data
//   mem_byte_enable            : CPU write mask
//   mem_resp, mem_rdata        : one-cycle completion pulse and held read data
//   pmem_req/we/addr/wdata/wmask : physical bus request side (word-aligned)
//   pmem_ack, pmem_rdata       : physical bus completion and read data
//   err_clear, bus_err         : sticky error flag (timeout or read+write) and its clear
module pmem_bridge
  import pmem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter rv32i_word   ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mem_read,
  input  logic           mem_write,
  input  rv32i_word      mem_address,
  input  rv32i_word      mem_wdata,
  input  rv32i_mem_wmask mem_byte_enable,
  output logic           mem_resp,
  output rv32i_word      mem_rdata,
  output logic           pmem_req,
  output logic           pmem_we,
  output rv32i_word      pmem_addr,
  output rv32i_word      pmem_wdata,
  output rv32i_mem_wmask pmem_wmask,
  input  logic           pmem_ack,
  input  rv32i_word      pmem_rdata,
  input  logic           err_clear,
  output logic           bus_err
);
  pmem_bridge_state_t state, state_next;
  logic accept, expired, timeout, set_err;
  assign accept  = state == IDLE && (mem_read || mem_write);
  assign timeout = state == BUSY && !pmem_ack && expired;
  assign set_err = (accept && mem_read && mem_write) || timeout;
  // req and resp decode straight from state flops, so reset drops them immediately
  assign pmem_req = state == BUSY;
  assign mem_resp = state == RESP;
  pmem_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .enable  (state == BUSY),
    .expired (expired)
  );
  always_comb begin
    state_next = state == IDLE ? (accept ? BUSY : IDLE)
               : state == BUSY ? ((pmem_ack || expired) ? RESP : BUSY)
               : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pmem_we    <= 1'b0;
      pmem_addr  <= '0;
      pmem_wdata <= '0;
      pmem_wmask <= '0;
      mem_rdata  <= '0;
      bus_err    <= 1'b0;
    end else begin
      state   <= state_next;
      bus_err <= set_err || (bus_err && !err_clear);
      if (accept) begin
        pmem_we    <= mem_write;
        pmem_addr  <= {mem_address[31:2], 2'b00};
        pmem_wdata <= mem_wdata;
        pmem_wmask <= mem_write ? mem_byte_enable : 4'b0000;
      end
      if (state == BUSY && !pmem_we && pmem_ack) mem_rdata <= pmem_rdata;
      else if (timeout && !pmem_we) mem_rdata <= ERR_RDATA;
    end
  end
endmodule
